// File: rtl/ball_logic.sv
// ball_logic: free-running ball motion generator for the pong logic.
// Each axis moves by +/-SPEED on every clock edge. An axis reverses direction
// when its next step would leave 0..LIMIT.
//
// Ports:
//   clk        - sole clock; all state changes on the rising edge
//   reset      - synchronous, active-high; recentres the ball and sets both
//                directions to +SPEED
//   ball_hpos  - registered horizontal position, range 0..H_LIMIT
//   ball_vpos  - registered vertical position, range 0..V_LIMIT
module ball_logic #(
  parameter int H_LIMIT = 256,
  parameter int V_LIMIT = 240,
  parameter int SPEED   = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [8:0] ball_hpos,
  output logic [8:0] ball_vpos
);

  localparam logic [8:0] STEP_POS = 9'(SPEED);
  localparam logic [9:0] STEP_W   = 10'(SPEED);
  localparam logic [9:0] H_LIM_W  = 10'(H_LIMIT);
  localparam logic [9:0] V_LIM_W  = 10'(V_LIMIT);
  localparam logic [8:0] H_CENTRE = 9'(H_LIMIT / 2);
  localparam logic [8:0] V_CENTRE = 9'(V_LIMIT / 2);

  // Two's complement step registers, always +SPEED or -SPEED.
  logic [8:0] ball_horiz_move;
  logic [8:0] ball_vert_move;

  logic       ball_horiz_collide;
  logic       ball_vert_collide;

  logic [8:0] ball_hpos_d;
  logic [8:0] ball_vpos_d;
  logic [8:0] ball_horiz_move_d;
  logic [8:0] ball_vert_move_d;

  // Upper bound is checked at 10 bits so pos + SPEED cannot wrap.
  always_comb begin
    ball_horiz_collide =
      (!ball_horiz_move[8] && (({1'b0, ball_hpos} + STEP_W) > H_LIM_W)) ||
      ( ball_horiz_move[8] && (ball_hpos < STEP_POS));
    ball_vert_collide =
      (!ball_vert_move[8] && (({1'b0, ball_vpos} + STEP_W) > V_LIM_W)) ||
      ( ball_vert_move[8] && (ball_vpos < STEP_POS));
  end

  // On collision, step by the negated move in the same cycle.
  always_comb begin
    ball_hpos_d       = ball_hpos + ball_horiz_move;
    ball_horiz_move_d = ball_horiz_move;
    if (ball_horiz_collide) begin
      ball_hpos_d       = ball_hpos - ball_horiz_move;
      ball_horiz_move_d = '0 - ball_horiz_move;
    end

    ball_vpos_d      = ball_vpos + ball_vert_move;
    ball_vert_move_d = ball_vert_move;
    if (ball_vert_collide) begin
      ball_vpos_d      = ball_vpos - ball_vert_move;
      ball_vert_move_d = '0 - ball_vert_move;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ball_hpos       <= H_CENTRE;
      ball_vpos       <= V_CENTRE;
      ball_horiz_move <= STEP_POS;
      ball_vert_move  <= STEP_POS;
    end else begin
      ball_hpos       <= ball_hpos_d;
      ball_vpos       <= ball_vpos_d;
      ball_horiz_move <= ball_horiz_move_d;
      ball_vert_move  <= ball_vert_move_d;
    end
  end

endmodule

// File: tb/tb_ball_logic.sv
// Testbench for ball_logic: three instances with different parameter sets,
// driven from per-instance vector tables through an expected-value queue.
module tb_ball_logic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic [8:0] h_a, v_a, h_b, v_b, h_c, v_c;

  ball_logic #(.H_LIMIT(20), .V_LIMIT(20), .SPEED(2)) dut_a (
    .clk(clk), .reset(rst_a), .ball_hpos(h_a), .ball_vpos(v_a));
  ball_logic #(.H_LIMIT(20), .V_LIMIT(12), .SPEED(2)) dut_b (
    .clk(clk), .reset(rst_b), .ball_hpos(h_b), .ball_vpos(v_b));
  ball_logic #(.H_LIMIT(21), .V_LIMIT(21), .SPEED(3)) dut_c (
    .clk(clk), .reset(rst_c), .ball_hpos(h_c), .ball_vpos(v_c));

  typedef struct packed {
    logic       rst;
    logic [8:0] h, v, hm, vm;
    logic       hc, vc;
  } vec_t;

  vec_t tab_a[$], tab_b[$], tab_c[$];
  vec_t exp_q[$];

  int unsigned total = 0, bad = 0, step = 0;
  int sel = 0;

  logic [8:0] o_h, o_v, o_hm, o_vm;
  logic       o_hc, o_vc;

  always_comb begin
    o_h = h_a; o_v = v_a;
    o_hm = dut_a.ball_horiz_move; o_vm = dut_a.ball_vert_move;
    o_hc = dut_a.ball_horiz_collide; o_vc = dut_a.ball_vert_collide;
    if (sel == 1) begin
      o_h = h_b; o_v = v_b;
      o_hm = dut_b.ball_horiz_move; o_vm = dut_b.ball_vert_move;
      o_hc = dut_b.ball_horiz_collide; o_vc = dut_b.ball_vert_collide;
    end else if (sel == 2) begin
      o_h = h_c; o_v = v_c;
      o_hm = dut_c.ball_horiz_move; o_vm = dut_c.ball_vert_move;
      o_hc = dut_c.ball_horiz_collide; o_vc = dut_c.ball_vert_collide;
    end
  end

  function automatic vec_t mk(logic r, logic [8:0] h, logic [8:0] v,
                              logic [8:0] hm, logic [8:0] vm, logic hc, logic vc);
    vec_t e;
    e.rst = r; e.h = h; e.v = v; e.hm = hm; e.vm = vm; e.hc = hc; e.vc = vc;
    return e;
  endfunction

  // Symmetric-axis entry for dut_a.
  function automatic vec_t sa(logic r, logic [8:0] p, logic [8:0] m, logic c);
    return mk(r, p, p, m, m, c, c);
  endfunction

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, step, got, want);
    end
  endtask

  task automatic run_table(input int which, input vec_t tab[$]);
    vec_t e;
    sel = which;
    foreach (tab[i]) begin
      step = i;
      case (which)
        0: rst_a = tab[i].rst;
        1: rst_b = tab[i].rst;
        default: rst_c = tab[i].rst;
      endcase
      exp_q.push_back(tab[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      chk("hpos", o_h, e.h);
      chk("vpos", o_v, e.v);
      chk("hmove", o_hm, e.hm);
      chk("vmove", o_vm, e.vm);
      chk("hcollide", {8'd0, o_hc}, {8'd0, e.hc});
      chk("vcollide", {8'd0, o_vc}, {8'd0, e.vc});
    end
  endtask

  localparam logic [8:0] P2 = 9'h002, N2 = 9'h1fe, P3 = 9'h003, N3 = 9'h1fd;

  initial begin
    logic [8:0] prev_h, prev_v, dh, dv;

    // dut_a (20,20,2): reset hold, forward run, upper/lower bounce, mid-run reset.
    for (int i = 0; i < 3; i++) tab_a.push_back(sa(1, 10, P2, 0));
    for (int p = 12; p <= 18; p += 2) tab_a.push_back(sa(0, 9'(p), P2, 0));
    tab_a.push_back(sa(0, 20, P2, 1));
    for (int p = 18; p >= 2; p -= 2) tab_a.push_back(sa(0, 9'(p), N2, 0));
    tab_a.push_back(sa(0, 0, N2, 1));
    for (int p = 2; p <= 18; p += 2) tab_a.push_back(sa(0, 9'(p), P2, 0));
    tab_a.push_back(sa(0, 20, P2, 1));
    for (int p = 18; p >= 6; p -= 2) tab_a.push_back(sa(0, 9'(p), N2, 0));
    tab_a.push_back(sa(1, 10, P2, 0));
    tab_a.push_back(sa(0, 12, P2, 0));
    tab_a.push_back(sa(0, 14, P2, 0));

    // dut_b (20,12,2): independent axes, simultaneous collide at h=0,v=12.
    tab_b.push_back(mk(1, 10,  6, P2, P2, 0, 0));
    tab_b.push_back(mk(1, 10,  6, P2, P2, 0, 0));
    tab_b.push_back(mk(0, 12,  8, P2, P2, 0, 0));
    tab_b.push_back(mk(0, 14, 10, P2, P2, 0, 0));
    tab_b.push_back(mk(0, 16, 12, P2, P2, 0, 1));
    tab_b.push_back(mk(0, 18, 10, P2, N2, 0, 0));
    tab_b.push_back(mk(0, 20,  8, P2, N2, 1, 0));
    tab_b.push_back(mk(0, 18,  6, N2, N2, 0, 0));
    tab_b.push_back(mk(0, 16,  4, N2, N2, 0, 0));
    tab_b.push_back(mk(0, 14,  2, N2, N2, 0, 0));
    tab_b.push_back(mk(0, 12,  0, N2, N2, 0, 1));
    tab_b.push_back(mk(0, 10,  2, N2, P2, 0, 0));
    tab_b.push_back(mk(0,  8,  4, N2, P2, 0, 0));
    tab_b.push_back(mk(0,  6,  6, N2, P2, 0, 0));
    tab_b.push_back(mk(0,  4,  8, N2, P2, 0, 0));
    tab_b.push_back(mk(0,  2, 10, N2, P2, 0, 0));
    tab_b.push_back(mk(0,  0, 12, N2, P2, 1, 1));
    tab_b.push_back(mk(0,  2, 10, P2, N2, 0, 0));

    // dut_c (21,21,3): unreachable limit, odd step.
    tab_c.push_back(mk(1, 10, 10, P3, P3, 0, 0));
    tab_c.push_back(mk(1, 10, 10, P3, P3, 0, 0));
    tab_c.push_back(mk(0, 13, 13, P3, P3, 0, 0));
    tab_c.push_back(mk(0, 16, 16, P3, P3, 0, 0));
    tab_c.push_back(mk(0, 19, 19, P3, P3, 1, 1));
    tab_c.push_back(mk(0, 16, 16, N3, N3, 0, 0));
    tab_c.push_back(mk(0, 13, 13, N3, N3, 0, 0));
    tab_c.push_back(mk(0, 10, 10, N3, N3, 0, 0));
    tab_c.push_back(mk(0,  7,  7, N3, N3, 0, 0));
    tab_c.push_back(mk(0,  4,  4, N3, N3, 0, 0));
    tab_c.push_back(mk(0,  1,  1, N3, N3, 1, 1));
    tab_c.push_back(mk(0,  4,  4, P3, P3, 0, 0));
    tab_c.push_back(mk(0,  7,  7, P3, P3, 0, 0));

    @(negedge clk);
    run_table(0, tab_a);
    run_table(1, tab_b);
    run_table(2, tab_c);

    // dut_c free run: range and step-size invariants.
    for (int i = 0; i < 60; i++) begin
      step = i;
      prev_h = h_c; prev_v = v_c;
      @(posedge clk); #1;
      dh = h_c - prev_h;
      dv = v_c - prev_v;
      chk("c_hrange", {8'd0, (h_c <= 9'd21)}, 9'd1);
      chk("c_vrange", {8'd0, (v_c <= 9'd21)}, 9'd1);
      chk("c_hstep", {8'd0, (dh == P3 || dh == N3)}, 9'd1);
      chk("c_vstep", {8'd0, (dv == P3 || dv == N3)}, 9'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
